ma_filter_ps: RTL

Parametrised streaming moving-average filter for signed two's-complement samples. The window length is selectable at run time (2^win_sel, up to 2^LOG2_WIN_MAX). It uses a running-sum accumulator over a circular delay line, so cost is one add and one subtract per sample, independent of window length. It has valid-qualified input and output, tracks window fill, and supports a synchronous flush. It sits in the DSP datapath wherever the fixed 8-tap averager was used.

---
 rtl/ma_pkg.sv | 24 ++
 rtl/ma_delay_line.sv | 40 ++++
 rtl/ma_filter_ps.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ma_pkg.sv
// rtl/ma_pkg.sv - shared sizing and window-select helpers for the moving-average filter
//
// Purpose: constant functions used to size the filter ports and datapath.
//   sel_w     : width of the window-exponent input for a given LOG2_WIN_MAX
//   acc_w     : running-sum width; DATA_W + LOG2_WIN_MAX bits cannot overflow
//               because the sum never holds more than 2^LOG2_WIN_MAX samples
//   clamp_sel : limits a requested window exponent to LOG2_WIN_MAX
// Ports: none (package).

package ma_pkg;

  function automatic int sel_w(input int log2_win_max);
    return (log2_win_max < 1) ? 1 : $clog2(log2_win_max + 1);
  endfunction

  function automatic int acc_w(input int data_w, input int log2_win_max);
    return data_w + log2_win_max;
  endfunction

  function automatic int clamp_sel(input int sel, input int log2_win_max);
    return (sel > log2_win_max) ? log2_win_max : sel;
  endfunction

endpackage

// File: rtl/ma_delay_line.sv
// rtl/ma_delay_line.sv - circular sample buffer with offset read port
//
// Purpose: 2^ADDR_W x DATA_W sample store. One synchronous write port and one
// asynchronous read port addressed as (wr_addr - rd_offset) mod depth, so the
// read returns the pre-write contents of the slot (read before write).
// No reset: contents are masked upstream until they have been written.
// Ports:
//   clk       in   clock
//   wr_en     in   write strobe
//   wr_addr   in   write slot (also the base of the read address)
//   wr_data   in   sample to store
//   rd_offset in   distance back from wr_addr to read (0 reads the slot being written)
//   rd_data   out  stored sample at wr_addr - rd_offset

module ma_delay_line #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_offset,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] rd_addr;

  // Modulo arithmetic falls out of the natural ADDR_W-bit wrap.
  assign rd_addr = wr_addr - rd_offset;
  assign rd_data = mem[rd_addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/ma_filter_ps.sv
// rtl/ma_filter_ps.sv - streaming moving-average filter with run-time window select
//
// Purpose: running-sum moving average of signed samples over a window of
// 2^k samples (k = win_sel clamped to LOG2_WIN_MAX). One add and one subtract
// per accepted sample; latency 1 cycle. During fill the partial sum is still
// divided by the full window; out_full marks a complete window.
// Build option: define MA_ROUND_EN to round half toward +inf instead of floor.
// Ports:
//   clk       in   clock
//   rst_n     in   synchronous active-low reset
//   clear     in   synchronous flush of sum and fill count (sample discarded)
//   win_sel   in   window exponent k; a change from last cycle also flushes
//   in_valid  in   sample strobe, no backpressure
//   in_data   in   signed sample
//   out_valid out  one-cycle pulse per accepted sample
//   out_data  out  signed average, holds between pulses
//   out_full  out  average covers a full window

module ma_filter_ps
  import ma_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int LOG2_WIN_MAX = 3,
  localparam int SEL_W       = sel_w(LOG2_WIN_MAX)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [SEL_W-1:0]  win_sel,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_full
);

  localparam int ACC_W  = acc_w(DATA_W, LOG2_WIN_MAX);
  localparam int EXT_W  = ACC_W + 1;
  localparam int FILL_W = LOG2_WIN_MAX + 1;
  localparam int WMAX   = 1 << LOG2_WIN_MAX;

  logic        [SEL_W-1:0]        k_cur;
  logic        [SEL_W-1:0]        k_reg;
  logic                           flush;
  logic        [FILL_W-1:0]       win_len;
  logic        [FILL_W-1:0]       fill;
  logic        [FILL_W-1:0]       fill_next;
  logic                           window_full;
  logic        [LOG2_WIN_MAX-1:0] wr_ptr;
  logic                           wr_en;
  logic        [DATA_W-1:0]       rd_data;
  logic signed [ACC_W-1:0]        acc;
  logic signed [ACC_W-1:0]        acc_next;
  logic signed [ACC_W-1:0]        x_ext;
  logic signed [ACC_W-1:0]        old_ext;
  logic signed [EXT_W-1:0]        pre_shift;
  logic        [DATA_W-1:0]       avg;

  assign k_cur   = SEL_W'(clamp_sel(int'(win_sel), LOG2_WIN_MAX));
  assign flush   = clear | (k_cur != k_reg);
  assign win_len = FILL_W'(1) << k_cur;

  // Until the window has filled there is no sample to retire.
  assign window_full = (fill >= win_len);
  assign fill_next   = (fill == FILL_W'(WMAX)) ? fill : fill + FILL_W'(1);
  assign wr_en       = rst_n & ~flush & in_valid;

  assign x_ext    = ACC_W'($signed(in_data));
  assign old_ext  = window_full ? ACC_W'($signed(rd_data)) : '0;
  assign acc_next = acc + x_ext - old_ext;

`ifdef MA_ROUND_EN
  logic signed [EXT_W-1:0] rnd;
  // Half an LSB of the output: 2^(k-1), and zero when k = 0.
  assign rnd       = (EXT_W'(1) << k_cur) >> 1;
  assign pre_shift = EXT_W'(acc_next) + rnd;
`else
  assign pre_shift = EXT_W'(acc_next);
`endif

  // Arithmetic shift gives floor division; the result always fits DATA_W.
  assign avg = DATA_W'(pre_shift >>> k_cur);

  // A window of WMAX wraps the offset to 0, reading the slot about to be overwritten.
  ma_delay_line #(
    .DATA_W (DATA_W),
    .ADDR_W (LOG2_WIN_MAX)
  ) u_delay_line (
    .clk       (clk),
    .wr_en     (wr_en),
    .wr_addr   (wr_ptr),
    .wr_data   (in_data),
    .rd_offset (win_len[LOG2_WIN_MAX-1:0]),
    .rd_data   (rd_data)
  );

  always_ff @(posedge clk) begin
    // Track win_sel even in reset so the first cycle after reset is not a flush.
    k_reg <= k_cur;
    if (!rst_n) begin
      acc       <= '0;
      fill      <= '0;
      wr_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_full  <= 1'b0;
    end else if (flush) begin
      acc       <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      out_full  <= 1'b0;
    end else if (in_valid) begin
      acc       <= acc_next;
      fill      <= fill_next;
      wr_ptr    <= wr_ptr + LOG2_WIN_MAX'(1);
      out_valid <= 1'b1;
      out_data  <= avg;
      out_full  <= (fill_next >= win_len);
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule
